// File: rtl/csr_pipe_chain.sv
// CSR pipeline chain from EX to WB. Each stage has its own bubble and flush.
// The new CSR value is computed at EX. In-flight CSR writes are forwarded to the instruction entering EX.
module csr_pipe_chain #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 12,
  parameter int STAGES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] bubble,
  input  logic [STAGES-1:0] flush,
  input  logic              in_valid,
  input  logic [1:0]        in_mask_func,
  input  logic              in_csr_read_en,
  input  logic              in_csr_write_en,
  input  logic [ADDR_W-1:0] in_csr_dest,
  input  logic [XLEN-1:0]   in_csr_out,
  input  logic [XLEN-1:0]   in_operand,
  output logic              ex_valid,
  output logic [1:0]        ex_mask_func,
  output logic              ex_csr_read_en,
  output logic              ex_csr_write_en,
  output logic [ADDR_W-1:0] ex_csr_dest,
  output logic [XLEN-1:0]   ex_operand,
  output logic [XLEN-1:0]   ex_csr_out,
  output logic [XLEN-1:0]   ex_csr_new,
  output logic              ex_fwd_hit,
  output logic              wb_csr_we,
  output logic [ADDR_W-1:0] wb_csr_dest,
  output logic [XLEN-1:0]   wb_csr_new
);

  localparam logic [1:0] MF_NONE = 2'b00;
  localparam logic [1:0] MF_RW   = 2'b01;
  localparam logic [1:0] MF_RS   = 2'b10;
  localparam logic [1:0] MF_RC   = 2'b11;

  typedef struct packed {
    logic              valid;
    logic [1:0]        mask_func;
    logic              read_en;
    logic              write_en;
    logic [ADDR_W-1:0] dest;
    logic [XLEN-1:0]   old_val;
    logic [XLEN-1:0]   operand;
    logic [XLEN-1:0]   new_val;
    logic              fwd_hit;
  } stage_t;

  stage_t            stage_q [STAGES];
  stage_t            stage_d [STAGES];
  stage_t            id_slot;
  logic [XLEN-1:0]   eff_new [STAGES];
  logic              fwd_hit;
  logic [XLEN-1:0]   fwd_val;
  int                prev;

  always_comb begin
    ex_csr_new = stage_q[0].old_val;
    case (stage_q[0].mask_func)
      MF_RW:   ex_csr_new = stage_q[0].operand;
      MF_RS:   ex_csr_new = stage_q[0].old_val | stage_q[0].operand;
      MF_RC:   ex_csr_new = stage_q[0].old_val & ~stage_q[0].operand;
      MF_NONE: ex_csr_new = stage_q[0].old_val;
      default: ex_csr_new = stage_q[0].old_val;
    endcase
  end

  // Stage 0 has no stored new value yet, so its combinational result stands in for it
  always_comb begin
    eff_new[0] = ex_csr_new;
    for (int j = 1; j < STAGES; j++) begin
      eff_new[j] = stage_q[j].new_val;
    end
  end

  // Scan oldest to youngest so the lowest-index match overwrites earlier ones
  always_comb begin
    fwd_hit = 1'b0;
    fwd_val = in_csr_out;
    if (in_valid && (in_csr_read_en || in_csr_write_en)) begin
      for (int j = STAGES - 1; j >= 0; j--) begin
        if (stage_q[j].valid && stage_q[j].write_en && (stage_q[j].dest == in_csr_dest)) begin
          fwd_hit = 1'b1;
          fwd_val = eff_new[j];
        end
      end
    end
  end

  always_comb begin
    id_slot           = '0;
    id_slot.valid     = in_valid;
    id_slot.mask_func = in_mask_func;
    id_slot.read_en   = in_csr_read_en;
    id_slot.write_en  = in_csr_write_en;
    id_slot.dest      = in_csr_dest;
    id_slot.old_val   = fwd_val;
    id_slot.operand   = in_operand;
    id_slot.fwd_hit   = fwd_hit;
  end

  // A stage whose upstream is held takes an empty slot so the held instruction is not duplicated
  always_comb begin
    prev = 0;
    for (int i = 0; i < STAGES; i++) begin
      prev       = (i > 0) ? i - 1 : 0;
      stage_d[i] = stage_q[i];
      if (!bubble[i]) begin
        if (flush[i]) begin
          stage_d[i] = '0;
        end else if (i == 0) begin
          stage_d[i] = id_slot;
        end else if (bubble[prev]) begin
          stage_d[i] = '0;
        end else begin
          stage_d[i]         = stage_q[prev];
          stage_d[i].new_val = eff_new[prev];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < STAGES; i++) begin
      if (rst) begin
        stage_q[i] <= '0;
      end else begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign ex_valid        = stage_q[0].valid;
  assign ex_mask_func    = stage_q[0].mask_func;
  assign ex_csr_read_en  = stage_q[0].read_en;
  assign ex_csr_write_en = stage_q[0].write_en;
  assign ex_csr_dest     = stage_q[0].dest;
  assign ex_operand      = stage_q[0].operand;
  assign ex_csr_out      = stage_q[0].old_val;
  assign ex_fwd_hit      = stage_q[0].fwd_hit;

  // Gating with rst keeps the CSR file from taking a write on the reset edge
  assign wb_csr_we   = stage_q[STAGES-1].valid & stage_q[STAGES-1].write_en & ~rst;
  assign wb_csr_dest = stage_q[STAGES-1].dest;
  assign wb_csr_new  = stage_q[STAGES-1].new_val;

endmodule

// File: doc/csr_pipe_chain.md
# csr_pipe_chain

Parametrised CSR pipeline chain: carries CSR instruction fields from ID through `STAGES` segment registers (EX, MEM, …, WB) with per-stage bubble and flush. It computes the new CSR value at EX and forwards in-flight CSR writes to a younger CSR instruction entering EX. This replaces the single ID/EX CSR segment register. The last stage drives the CSR file write port.

## Interface

Parameters:
- `XLEN`, 32, data width.
- `ADDR_W`, 12, CSR address width.
- `STAGES`, 3, number of segment registers (stage 0 = EX, stage `STAGES-1` = WB); legal range 2..8.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `bubble`  in  `STAGES`  bit i holds stage i.
- `flush`  in  `STAGES`  bit i loads an empty slot into stage i.
- `in_valid`  in  1  ID slot holds a real instruction.
- `in_mask_func`  in  2  00 none, 01 RW, 10 RS, 11 RC.
- `in_csr_read_en`  in  1  instruction reads a CSR.
- `in_csr_write_en`  in  1  instruction writes a CSR.
- `in_csr_dest`  in  `ADDR_W`  CSR address.
- `in_csr_out`  in  `XLEN`  CSR file value read in ID (may be stale).
- `in_operand`  in  `XLEN`  rs1 value or zimm.
- `ex_valid`, `ex_mask_func`, `ex_csr_read_en`, `ex_csr_write_en`, `ex_csr_dest`, `ex_operand`  out  stage-0 copies of the inputs.
- `ex_csr_out`  out  `XLEN`  stage-0 old CSR value after forwarding (rd result).
- `ex_csr_new`  out  `XLEN`  combinational new value from stage 0.
- `ex_fwd_hit`  out  1  stage-0 value was forwarded at capture.
- `wb_csr_we`  out  1  `valid & csr_write_en` of the last stage.
- `wb_csr_dest`  out  `ADDR_W`  last-stage address.
- `wb_csr_new`  out  `XLEN`  last-stage new value.

## Operation

- Each stage holds: valid, mask_func, read_en, write_en, dest, old value, operand, new value, fwd_hit. The new value is meaningful from stage 1 onward.
- New value (from stage 0): RW = operand; RS = old | operand; RC = old & ~operand; 00 = old. It is captured into stage 1.
- Stage update priority per edge: `rst` > `bubble[i]` (hold) > `flush[i]` (empty slot) > advance.
- An empty slot is all fields zero.
- Advance rule:
  - Stage 0 loads ID inputs.
  - Stage i>0 loads stage i-1.
  - If `bubble[i-1]`=1 and stage i advances, stage i loads an empty slot instead, so there is no duplication.
- Forwarding at stage-0 load:
  - If `in_valid` and (read_en or write_en), compare `in_csr_dest` against every stage j (pre-edge contents) with valid & write_en.
  - The youngest (lowest j) match supplies the old value: stage 0 supplies `ex_csr_new`, stage j≥1 supplies its stored new value.
  - On a match, set `ex_fwd_hit`. With no match, `in_csr_out` is used.
- Forwarding covers the write the CSR file performs at the same edge from WB, because WB is still in flight when ID reads.
- Stages with `write_en`=1 but mask_func 00 write the old value back unchanged.

## Timing

- Reset: every stage is cleared to an empty slot, so all outputs are 0, including `wb_csr_we`=0.
- Latency: ID to EX 1 cycle; ID to WB `STAGES` cycles with no stalls.
- `ex_csr_new` is combinational from stage-0 registers. All other outputs are registered.
- Held stages keep every field, including fwd_hit. Forwarding from a held stage uses its stable contents.
- Flush with bubble on the same stage: hold wins.
- `rst` mid-stream discards all in-flight writes. No write is issued on the reset edge.

## Test plan

1. Reset with `STAGES`=3, then stream CSRRW x=0x300, operand 0x8 → `wb_csr_we`=1 with dest 0x300 and new 0x8 exactly 3 cycles after ID.
2. CSRRS on 0x305, old 0x00F0, operand 0x0F00, followed back-to-back by CSRRC on 0x305 (stale old 0x00F0), operand 0x00F0 → second instruction gets `ex_fwd_hit`=1, `ex_csr_out`=0x0FF0, new 0x0F00.
3. Writes to 0x300 sitting in MEM (0x1) and EX (0x2) when a reader of 0x300 loads → youngest wins, `ex_csr_out`=0x2.
4. `bubble`=001 for 2 cycles with a write in EX → EX held, MEM receives empty slots, and no extra `wb_csr_we` pulse appears.
5. `flush`=001 and `bubble`=001 in the same cycle → stage 0 unchanged. Then `flush`=001 alone → `ex_valid`=0 and nothing reaches WB.
6. Assert `rst` while writes occupy all stages → the next cycle all outputs are 0 and `wb_csr_we` never rises for those instructions. Repeat case 1 with `STAGES`=5 → latency 5.
